// File: rtl/regression_lineaire_lms_if.sv
// Sample, load and prediction signals for the LMS linear-regression block.
// The master drives samples and loads, and the slave returns predictions and weights.
interface regression_lineaire_lms_if #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 8,
    parameter int unsigned WW = 16,
    parameter int unsigned OW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic          mode;
    logic [XW-1:0] taille;
    logic [YW-1:0] prix;
    logic          load_en;
    logic [WW-1:0] load_w;
    logic [WW-1:0] load_b;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] y;
    logic [WW-1:0] w;
    logic [WW-1:0] b;

    modport master (
        output in_valid, mode, taille, prix, load_en, load_w, load_b, out_ready,
        input  in_ready, out_valid, y, w, b
    );

    modport slave (
        input  in_valid, mode, taille, prix, load_en, load_w, load_b, out_ready,
        output in_ready, out_valid, y, w, b
    );
endinterface

// File: rtl/regression_lineaire_lms.sv
// Single-feature linear regression y = w*taille + b with an LMS weight update in train mode.
// The weight and bias are fixed point with FRAC fractional bits, and the learning rate is 2^-MU_SHIFT.
//
// state | meaning
// IDLE  | waiting for a sample or a weight/bias load
// MUL   | register w * taille
// PRED  | form the floored, saturated prediction into y
// UPD   | LMS update of w and b (train only)
// OUT   | hold y until the consumer takes it
module regression_lineaire_lms #(
    parameter int unsigned XW       = 8,
    parameter int unsigned YW       = 8,
    parameter int unsigned WW       = 16,
    parameter int unsigned FRAC     = 8,
    parameter int unsigned MU_SHIFT = 4,
    parameter int unsigned OW       = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    regression_lineaire_lms_if.slave bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_MUL  = 3'd1;
    localparam logic [2:0] S_PRED = 3'd2;
    localparam logic [2:0] S_UPD  = 3'd3;
    localparam logic [2:0] S_OUT  = 3'd4;

    localparam int PW = WW + XW + 1;
    localparam int SW = PW + 2;
    localparam int EW = ((YW + 1 > OW) ? YW + 1 : OW) + 1;
    localparam int GW = EW + XW + 1 + FRAC;
    localparam int UW = GW + 2;

    localparam logic signed [SW-1:0] P_MAX = {{(SW-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [SW-1:0] P_MIN = {{(SW-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [UW-1:0] W_MAX = {{(UW-WW+1){1'b0}}, {(WW-1){1'b1}}};
    localparam logic signed [UW-1:0] W_MIN = {{(UW-WW+1){1'b1}}, {(WW-1){1'b0}}};

    logic [2:0]           state;
    logic                 mode_r;
    logic [XW-1:0]        taille_r;
    logic [YW-1:0]        prix_r;
    logic signed [PW-1:0] prod_r;
    logic signed [OW-1:0] y_r;
    logic signed [WW-1:0] w_r;
    logic signed [WW-1:0] b_r;

    logic signed [PW-1:0] w_px, t_px, prod_c;
    logic signed [SW-1:0] prod_sx, b_sx, p_c;
    logic signed [OW-1:0] p_sat;
    logic signed [GW-1:0] err_c, t_gx, grad_w, grad_b;
    logic signed [UW-1:0] w_new, b_new;
    logic signed [WW-1:0] w_sat, b_sat;

    always_comb begin
        w_px   = $signed({{(PW-WW){w_r[WW-1]}}, w_r});
        t_px   = $signed({{(PW-XW){1'b0}}, taille_r});
        prod_c = w_px * t_px;

        // Both terms are floored before the add, so a fractional bias contributes only its integer part.
        prod_sx = $signed({{(SW-PW){prod_r[PW-1]}}, prod_r});
        b_sx    = $signed({{(SW-WW){b_r[WW-1]}}, b_r});
        p_c     = (prod_sx >>> FRAC) + (b_sx >>> FRAC);
        if (p_c > P_MAX)
            p_sat = P_MAX[OW-1:0];
        else if (p_c < P_MIN)
            p_sat = P_MIN[OW-1:0];
        else
            p_sat = p_c[OW-1:0];

        // The error uses the registered prediction y, which is the same value that was presented.
        err_c  = $signed({{(GW-YW){1'b0}}, prix_r}) - $signed({{(GW-OW){y_r[OW-1]}}, y_r});
        t_gx   = $signed({{(GW-XW){1'b0}}, taille_r});
        grad_w = ((err_c * t_gx) <<< FRAC) >>> MU_SHIFT;
        grad_b = (err_c <<< FRAC) >>> MU_SHIFT;

        w_new = $signed({{(UW-WW){w_r[WW-1]}}, w_r}) + $signed({{(UW-GW){grad_w[GW-1]}}, grad_w});
        b_new = $signed({{(UW-WW){b_r[WW-1]}}, b_r}) + $signed({{(UW-GW){grad_b[GW-1]}}, grad_b});
        if (w_new > W_MAX)
            w_sat = W_MAX[WW-1:0];
        else if (w_new < W_MIN)
            w_sat = W_MIN[WW-1:0];
        else
            w_sat = w_new[WW-1:0];
        if (b_new > W_MAX)
            b_sat = W_MAX[WW-1:0];
        else if (b_new < W_MIN)
            b_sat = W_MIN[WW-1:0];
        else
            b_sat = b_new[WW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            mode_r   <= 1'b0;
            taille_r <= '0;
            prix_r   <= '0;
            prod_r   <= '0;
            y_r      <= '0;
            w_r      <= '0;
            b_r      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.load_en) begin
                        w_r <= bus.load_w;
                        b_r <= bus.load_b;
                    end else if (bus.in_valid) begin
                        mode_r   <= bus.mode;
                        taille_r <= bus.taille;
                        prix_r   <= bus.prix;
                        state    <= S_MUL;
                    end
                end
                S_MUL: begin
                    prod_r <= prod_c;
                    state  <= S_PRED;
                end
                S_PRED: begin
                    y_r   <= p_sat;
                    state <= mode_r ? S_UPD : S_OUT;
                end
                S_UPD: begin
                    w_r   <= w_sat;
                    b_r   <= b_sat;
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE) && !bus.load_en;
    assign bus.out_valid = (state == S_OUT);
    assign bus.y         = y_r;
    assign bus.w         = w_r;
    assign bus.b         = b_r;
endmodule

// File: tb/tb_regression_lineaire_lms.sv
// Directed bench for regression_lineaire_lms; expected values are worked out by hand in fixed point.
module tb_regression_lineaire_lms;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   lat;

    regression_lineaire_lms_if #(.XW(8), .YW(8), .WW(16), .OW(16)) bus ();

    regression_lineaire_lms #(
        .XW(8), .YW(8), .WW(16), .FRAC(8), .MU_SHIFT(4), .OW(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] lw, input logic [15:0] lb);
        bus.load_en = 1'b1;
        bus.load_w  = lw;
        bus.load_b  = lb;
        tick();
        bus.load_en = 1'b0;
    endtask

    // Returns one tick after the accept edge, with the DUT in MUL.
    task automatic start(input logic m, input logic [7:0] t, input logic [7:0] p);
        bus.mode     = m;
        bus.taille   = t;
        bus.prix     = p;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (!bus.out_valid && n < 12) begin
            tick();
            n++;
        end
        if (!bus.out_valid) n = 99;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.mode      = 1'b0;
        bus.taille    = '0;
        bus.prix      = '0;
        bus.load_en   = 1'b0;
        bus.load_w    = '0;
        bus.load_b    = '0;
        bus.out_ready = 1'b1;
        repeat (2) tick();
        rst = 1'b0;

        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_w", bus.w, 0);
        chk("rst_b", bus.b, 0);
        chk("rst_y", bus.y, 0);

        // train from zero: p=0, err=16, both grads = 16*256/16 = 256
        start(1'b1, 8'd1, 8'd16);
        wait_out(lat);
        chk("train0_lat", lat, 4);
        chk("train0_y", bus.y, 16'h0000);
        chk("train0_w", bus.w, 16'h0100);
        chk("train0_b", bus.b, 16'h0100);
        tick();
        chk("train0_back_idle", bus.in_ready, 1);

        // predict: 2.0*10 + 5 = 25
        load(16'h0200, 16'h0500);
        chk("load_w", bus.w, 16'h0200);
        chk("load_b", bus.b, 16'h0500);
        start(1'b0, 8'd10, 8'd0);
        wait_out(lat);
        chk("pred_lat", lat, 3);
        chk("pred_y", bus.y, 16'd25);
        chk("pred_w_kept", bus.w, 16'h0200);
        chk("pred_b_kept", bus.b, 16'h0500);
        tick();

        // weight saturates: p=127, err=128, w += 0x800 overflows
        load(16'h7FF0, 16'h0000);
        start(1'b1, 8'd1, 8'd255);
        wait_out(lat);
        chk("sat_lat", lat, 4);
        chk("sat_y", bus.y, 16'd127);
        chk("sat_w", bus.w, 16'h7FFF);
        chk("sat_b", bus.b, 16'h0800);
        tick();

        // negative weight floors: -1.0*3 = -3
        load(16'hFF00, 16'h0000);
        start(1'b0, 8'd3, 8'd0);
        wait_out(lat);
        chk("neg_y", bus.y, 16'hFFFD);
        tick();

        // negative error: p=4, err=-3, w -= 12*16, b -= 3*16
        load(16'h0100, 16'h0000);
        start(1'b1, 8'd4, 8'd1);
        wait_out(lat);
        chk("negerr_y", bus.y, 16'd4);
        chk("negerr_w", bus.w, 16'h0040);
        chk("negerr_b", bus.b, 16'hFFD0);
        tick();

        // backpressure
        load(16'h0200, 16'h0500);
        bus.out_ready = 1'b0;
        start(1'b0, 8'd10, 8'd0);
        wait_out(lat);
        chk("bp_lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_out_valid", bus.out_valid, 1);
            chk("bp_y", bus.y, 16'd25);
            chk("bp_in_ready", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_release_valid", bus.out_valid, 0);
        chk("bp_release_ready", bus.in_ready, 1);

        // load outside IDLE is ignored; y = 3*5 + 1 = 16
        load(16'h0300, 16'h0100);
        start(1'b0, 8'd5, 8'd0);
        bus.load_en = 1'b1;
        bus.load_w  = 16'h1234;
        bus.load_b  = 16'h5678;
        wait_out(lat);
        bus.load_en = 1'b0;
        chk("busyload_lat", lat, 3);
        chk("busyload_y", bus.y, 16'd16);
        chk("busyload_w", bus.w, 16'h0300);
        chk("busyload_b", bus.b, 16'h0100);
        tick();

        // reset during UPD aborts the update
        load(16'h0100, 16'h0100);
        start(1'b1, 8'd2, 8'd50);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("rstupd_w", bus.w, 0);
        chk("rstupd_b", bus.b, 0);
        chk("rstupd_y", bus.y, 0);
        chk("rstupd_out_valid", bus.out_valid, 0);
        rst = 1'b0;
        tick();
        chk("rstupd_in_ready", bus.in_ready, 1);
        chk("rstupd_w_after", bus.w, 0);

        // load has priority over a simultaneous sample
        bus.load_en  = 1'b1;
        bus.load_w   = 16'h0300;
        bus.load_b   = 16'h0100;
        bus.in_valid = 1'b1;
        bus.mode     = 1'b0;
        bus.taille   = 8'd5;
        #1;
        chk("prio_in_ready_low", bus.in_ready, 0);
        tick();
        bus.load_en  = 1'b0;
        bus.in_valid = 1'b0;
        chk("prio_w", bus.w, 16'h0300);
        chk("prio_b", bus.b, 16'h0100);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("prio_no_accept", {bus.in_ready, bus.out_valid}, 2'b10);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regression_lineaire_lms.md
REGRESSION_LINEAIRE_LMS -- requirements
Module: regression_lineaire_lms

Interface
REQ-001 SHALL have parameter XW, default 8, meaning taille width (unsigned).
REQ-002 SHALL have parameter YW, default 8, meaning prix width (unsigned).
REQ-003 SHALL have parameter WW, default 16, meaning signed weight/bias width.
REQ-004 SHALL have parameter FRAC, default 8, meaning fractional bits of weight and bias.
REQ-005 SHALL have parameter MU_SHIFT, default 4, meaning learning rate 2^-MU_SHIFT.
REQ-006 SHALL have parameter OW, default 16, meaning signed prediction width.
REQ-007 SHALL use one clock; reset SHALL be synchronous and active-high.
REQ-008 clk  in  1  clock, rising edge.
REQ-009 rst  in  1  synchronous active-high reset.
REQ-010 in_valid  in  1  sample valid.
REQ-011 in_ready  out  1  block can accept a sample.
REQ-012 mode  in  1  0 = predict, 1 = train; sampled with the sample.
REQ-013 taille  in  XW  feature.
REQ-014 prix  in  YW  target; used in train only.
REQ-015 load_en  in  1  load weight and bias.
REQ-016 load_w  in  WW  weight to load.
REQ-017 load_b  in  WW  bias to load.
REQ-018 out_valid  out  1  prediction valid.
REQ-019 out_ready  in  1  consumer accepts the prediction.
REQ-020 y  out  OW  signed prediction.
REQ-021 w  out  WW  current weight.
REQ-022 b  out  WW  current bias.

Function
REQ-023 The FSM SHALL have states IDLE, MUL, PRED, UPD and OUT.
- IDLE->MUL on accept.
- MUL->PRED always.
- PRED->UPD if the latched mode is 1, else PRED->OUT.
- UPD->OUT always.
- OUT->IDLE when out_ready is 1.
REQ-024 in_ready SHALL be 1 only in IDLE with load_en at 0.
- A sample is accepted when in_valid and in_ready are both 1.
- On accept, taille, prix and mode SHALL be latched.
REQ-025 In MUL, the block SHALL register the product: w (signed) times zero-extended taille, full width.
REQ-026 In PRED, the block SHALL compute p = (product >>> FRAC) + (b >>> FRAC).
- Shifts are arithmetic, so the result is floored.
- p SHALL saturate to the OW signed range and be registered into y.
REQ-027 In UPD, the block SHALL compute err = zero-extended prix - p.
- w is updated to sat(w + ((err*taille) <<< FRAC >>> MU_SHIFT)).
- b is updated to sat(b + (err <<< FRAC >>> MU_SHIFT)).
- Saturation is to the WW signed range.
- Intermediates SHALL be wide enough that no overflow occurs before saturation.
REQ-028 y SHALL hold the pre-update prediction in train mode.
REQ-029 Latency from the accept edge to out_valid rising SHALL be:
- 3 cycles in predict mode;
- 4 cycles in train mode.
REQ-030 out_valid SHALL be 1 only in OUT.
- y SHALL stay stable while out_valid is 1 and out_ready is 0.
REQ-031 When load_en is 1 in IDLE, w and b SHALL take load_w and load_b on that edge.
- load_en has priority over in_valid: no sample is accepted that cycle.
- load_en outside IDLE SHALL be ignored.
REQ-032 A new sample SHALL be accepted no earlier than the cycle after OUT->IDLE.
- Throughput is therefore one sample per 4 or 5 cycles.
REQ-033 w and b SHALL change only on load or in UPD.

Reset
REQ-034 When rst is 1 on a clock edge, the block SHALL set:
- state to IDLE;
- w, b and y to 0;
- out_valid to 0;
- all latched inputs to 0.
REQ-035 Reset in any state, including mid-UPD, SHALL abort the transaction with no partial weight update.
- in_ready SHALL be 1 on the first cycle after rst falls.

Verification
REQ-036 Defaults. Load w=0x0200, b=0x0500; predict taille=10 -> y=25, out_valid rises 3 cycles after accept, w and b unchanged.
REQ-037 From reset, train taille=1, prix=16 -> y=0, w=0x0100, b=0x0100, out_valid rises 4 cycles after accept.
REQ-038 Load w=0x7FF0, b=0; train taille=1, prix=255 -> y=127, w saturates to 0x7FFF, b=0x0800.
REQ-039 Load w=0xFF00, b=0; predict taille=3 -> y=0xFFFD (-3, floor).
REQ-040 Backpressure. Hold out_ready=0 for 5 cycles in OUT -> y and out_valid stable, in_ready=0; then out_ready=1 -> IDLE on the next cycle.
REQ-041 Reset and priority.
- Assert rst during UPD -> w=b=0 and out_valid=0 on the next cycle.
- Assert load_en and in_valid together in IDLE -> load occurs and no sample is accepted.
